mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (I) and data-access port (D, lw/sw).
- Arbitrates the two requests, sequences each access through a wait-state counter, and returns read data with a one-cycle done pulse.
- Produces per-port stall signals that the pipeline control unit ORs into its stall/hold logic.
- Sits between the IF/MEM stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency, single-port unified memory
// between the instruction-fetch (I) and data-access (D) ports.
// One access at a time walks IDLE -> ACC (WAIT+1 cycles) -> RESP.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, D always wins a tie over I.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Ireq,
    input  logic [AW-1:0] Iaddr,
    output logic [DW-1:0] Irdata,
    output logic          Idone,
    input  logic          Dreq,
    input  logic          Dwe,
    input  logic [AW-1:0] Daddr,
    input  logic [DW-1:0] Dwdata,
    output logic [DW-1:0] Drdata,
    output logic          Ddone,
    output logic          Men,
    output logic          Mwe,
    output logic [AW-1:0] Maddr,
    output logic [DW-1:0] Mwdata,
    input  logic [DW-1:0] Mrdata,
    output logic          Istall,
    output logic          Dstall,
    output logic          Busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          d_wins;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie, the port that was not granted last time wins.
    assign d_wins = Dreq & (~Ireq | (last_q == OWN_I));
`else
    // The MEM-stage access is older than the fetch, so D wins a tie.
    assign d_wins = Dreq;
`endif

    // Next-state logic: grant and latch in IDLE, count wait states in ACC,
    // capture read data on the last ACC cycle, release after RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Dreq | Ireq) begin
                    state_d = S_ACC;
                    cnt_d   = WAIT_CNT;
                    owner_d = d_wins ? OWN_D : OWN_I;
                    addr_d  = d_wins ? Daddr : Iaddr;
                    we_d    = d_wins & Dwe;
                    if (d_wins) begin
                        wdata_d = Dwdata;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d = d_wins ? OWN_D : OWN_I;
`endif
                end
            end
            S_ACC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            drdata_d = Mrdata;
                        end else begin
                            irdata_d = Mrdata;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-access registers; reset aborts any access in flight.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= OWN_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q   <= OWN_I;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign Men    = (state_q == S_ACC);
    assign Mwe    = Men & we_q;
    assign Maddr  = addr_q;
    assign Mwdata = wdata_q;
    assign Idone  = (state_q == S_RESP) & (owner_q == OWN_I);
    assign Ddone  = (state_q == S_RESP) & (owner_q == OWN_D);
    assign Irdata = irdata_q;
    assign Drdata = drdata_q;
    assign Istall = Ireq & ~Idone;
    assign Dstall = Dreq & ~Ddone;
    assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a cycle-arithmetic model of
// the access timeline, and literal expectations from hand-worked examples.
// A second instance with WAIT=0 checks back-to-back throughput.
module tb_mem_port_arbiter;

    localparam int WT = 2;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic        Ireq = 1'b0, Dreq = 1'b0, Dwe = 1'b0;
    logic [31:0] Iaddr = '0, Daddr = '0, Dwdata = '0;
    logic [31:0] Irdata, Drdata, Maddr, Mwdata, Mrdata;
    logic        Idone, Ddone, Men, Mwe, Istall, Dstall, Busy;

    logic [31:0] irdata0, drdata0, maddr0, mwdata0, mrdata0;
    logic        idone0, ddone0, men0, mwe0, istall0, dstall0, busy0;

    int n_chk = 0, n_pass = 0;
    int mem_cnt = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'h8C01_0044;
    endfunction

    // Memory macro: read data is only valid on the last ACC cycle.
    always @(posedge Clk) mem_cnt <= Men ? mem_cnt + 1 : 0;
    always_comb Mrdata = (Men && mem_cnt == WT) ? rd_word(Maddr) : (32'hBAD0_0000 | 32'(mem_cnt));
    always_comb mrdata0 = men0 ? rd_word(maddr0) : 32'hBAD0_BAD0;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT(WT)) dut (
        .Clk(Clk), .Clrn(Clrn), .Ireq(Ireq), .Iaddr(Iaddr), .Irdata(Irdata), .Idone(Idone),
        .Dreq(Dreq), .Dwe(Dwe), .Daddr(Daddr), .Dwdata(Dwdata), .Drdata(Drdata), .Ddone(Ddone),
        .Men(Men), .Mwe(Mwe), .Maddr(Maddr), .Mwdata(Mwdata), .Mrdata(Mrdata),
        .Istall(Istall), .Dstall(Dstall), .Busy(Busy));

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT(0)) dut0 (
        .Clk(Clk), .Clrn(Clrn), .Ireq(Ireq), .Iaddr(Iaddr), .Irdata(irdata0), .Idone(idone0),
        .Dreq(Dreq), .Dwe(Dwe), .Daddr(Daddr), .Dwdata(Dwdata), .Drdata(drdata0), .Ddone(ddone0),
        .Men(men0), .Mwe(mwe0), .Maddr(maddr0), .Mwdata(mwdata0), .Mrdata(mrdata0),
        .Istall(istall0), .Dstall(dstall0), .Busy(busy0));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // Model: an access granted at edge g is in ACC after edges g..g+WT,
    // in RESP after edge g+WT+1, and the arbiter is free after edge g+WT+2.
    int          cyc = 0, m_g = 0;
    bit          m_busy = 0, m_own_d = 0, m_we = 0, m_last_d = 0, dw;
    logic [31:0] m_addr = '0, m_wdata = '0, exp_ir = '0, exp_dr = '0;

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_busy = 0; m_own_d = 0; m_we = 0; m_last_d = 0;
            m_addr = '0; m_wdata = '0; exp_ir = '0; exp_dr = '0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == m_g + WT + 1 && !m_we) begin
                    if (m_own_d) exp_dr = rd_word(m_addr);
                    else         exp_ir = rd_word(m_addr);
                end
                if (cyc == m_g + WT + 2) m_busy = 0;
            end else if (Dreq || Ireq) begin
`ifdef MEM_ARB_RR_EN
                dw = Dreq && (!Ireq || !m_last_d);
                m_last_d = dw;
`else
                dw = Dreq;
`endif
                m_busy = 1; m_g = cyc; m_own_d = dw;
                m_addr = dw ? Daddr : Iaddr;
                m_we = dw && Dwe;
                if (dw) m_wdata = Dwdata;
            end
        end
    end

    bit e_men, e_resp, e_idone, e_ddone;
    always @(negedge Clk) begin
        e_men   = m_busy && (cyc - m_g) <= WT;
        e_resp  = m_busy && (cyc == m_g + WT + 1);
        e_idone = e_resp && !m_own_d;
        e_ddone = e_resp && m_own_d;
        chk("busy", 32'(Busy), 32'(m_busy));
        chk("men", 32'(Men), 32'(e_men));
        chk("mwe", 32'(Mwe), 32'(e_men && m_we));
        chk("maddr", Maddr, m_addr);
        chk("idone", 32'(Idone), 32'(e_idone));
        chk("ddone", 32'(Ddone), 32'(e_ddone));
        chk("irdata", Irdata, exp_ir);
        chk("drdata", Drdata, exp_dr);
        chk("istall", 32'(Istall), 32'(Ireq && !e_idone));
        chk("dstall", 32'(Dstall), 32'(Dreq && !e_ddone));
        if (e_men && m_we) chk("mwdata", Mwdata, m_wdata);
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    int ci, c0, m0, cd;

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_men", 32'(Men | Mwe | Idone | Ddone), 0);
        chk("rst_maddr", Maddr, 0);
        chk("rst_mwdata", Mwdata, 0);
        chk("rst_rdata", Irdata | Drdata, 0);
        tick(); Clrn = 1'b1;
        tick();

        // Tie after reset: D first, I granted once D has finished
        Ireq = 1; Iaddr = 32'h80; Dreq = 1; Dwe = 0; Daddr = 32'h200;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n <= 8) chk("tie_istall", 32'(Istall), 1);
            if (n == 4) begin
                chk("tie_ddone", 32'(Ddone), 1);
                chk("tie_drdata", Drdata, 32'h8C01_0244);
                Dreq = 0;
            end
            if (n == 9) begin
                chk("tie_idone", 32'(Idone), 1);
                chk("tie_irdata", Irdata, 32'h8C01_00C4);
                chk("tie_istall_done", 32'(Istall), 0);
                Ireq = 0;
            end
            if (n == 10) chk("tie_idle", 32'(Busy), 0);
        end
        repeat (3) tick();

        // Single fetch; address change during ACC must be ignored
        Ireq = 1; Iaddr = 32'h40;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n <= 3) chk("rd_men", 32'(Men), 1);
            if (n == 2) Iaddr = 32'h44;
            if (n == 3) chk("rd_maddr_held", Maddr, 32'h40);
            if (n == 4) begin
                chk("rd_idone", 32'(Idone), 1);
                chk("rd_irdata", Irdata, 32'h8C01_0004);
                chk("rd_istall", 32'(Istall), 0);
                Ireq = 0;
            end
            if (n == 5) chk("rd_done_once", 32'(Idone), 0);
        end
        repeat (3) tick();

        // Store: latched we/addr/data, Drdata untouched
        Dreq = 1; Dwe = 1; Daddr = 32'h100; Dwdata = 32'hDEAD_BEEF;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n <= 3) begin
                chk("st_mwe", 32'(Mwe & Men), 1);
                chk("st_maddr", Maddr, 32'h100);
                chk("st_mwdata", Mwdata, 32'hDEAD_BEEF);
            end
            if (n == 2) begin Daddr = 32'h104; Dwdata = '0; Dwe = 0; end
            if (n == 4) begin
                chk("st_ddone", 32'(Ddone), 1);
                chk("st_drdata", Drdata, 32'h8C01_0244);
                Dreq = 0;
            end
            if (n == 5) chk("st_done_once", 32'(Ddone), 0);
        end
        repeat (3) tick();

        // Request dropped mid-access still completes
        Ireq = 1; Iaddr = 32'h44;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 1) Ireq = 0;
            if (n == 4) begin
                chk("drop_idone", 32'(Idone), 1);
                chk("drop_irdata", Irdata, 32'h8C01_0000);
            end
        end
        repeat (3) tick();

        // Reset in the second ACC cycle, then a fresh request
        Ireq = 1; Iaddr = 32'h48;
        tick(); tick();
        #1 Clrn = 0;
        #1;
        chk("arst_men", 32'(Men), 0);
        chk("arst_busy", 32'(Busy), 0);
        chk("arst_idone", 32'(Idone), 0);
        chk("arst_istall", 32'(Istall), 1);
        tick(); Clrn = 1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n <= 3) chk("arst_no_done", 32'(Idone), 0);
            if (n == 4) begin
                chk("arst_new_idone", 32'(Idone), 1);
                chk("arst_new_irdata", Irdata, 32'h8C01_000C);
                Ireq = 0;
            end
        end
        repeat (3) tick();

        // Back-to-back fetches held continuously
        ci = 0; c0 = 0; m0 = 0;
        Ireq = 1; Iaddr = 32'h50;
        for (int n = 1; n <= 15; n++) begin
            tick();
            ci += int'(Idone); c0 += int'(idone0); m0 += int'(men0);
            if (n == 15) Ireq = 0;
        end
        chk("b2b_idone_w2", 32'(ci), 3);
        chk("b2b_idone_w0", 32'(c0), 5);
        chk("b2b_men_w0", 32'(m0), 5);
        chk("b2b_irdata_w0", irdata0, 32'h8C01_0014);
        repeat (3) tick();

        // Both ports requesting continuously
        ci = 0; cd = 0;
        Ireq = 1; Iaddr = 32'h60; Dreq = 1; Dwe = 0; Daddr = 32'h300;
        for (int n = 1; n <= 20; n++) begin
            tick();
            ci += int'(Idone); cd += int'(Ddone);
            if (n == 4) chk("both_first_d", 32'(Ddone), 1);
        end
        Ireq = 0; Dreq = 0;
`ifdef MEM_ARB_RR_EN
        chk("rr_ddone_cnt", 32'(cd), 2);
        chk("rr_idone_cnt", 32'(ci), 2);
`else
        chk("fix_ddone_cnt", 32'(cd), 4);
        chk("fix_idone_cnt", 32'(ci), 0);
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
